seg_scan_driver: RTL

- Sequential scan controller for the Basys 3 four-digit seven-segment display.
- Time-multiplexes a 16-bit hex value across the four digits.
- Generates the 2-bit digit select consumed by the digit-select mux, the active-low one-hot anode drive, and decoded active-low segments.
- Adds anti-ghosting dead time, leading-zero suppression and frame-synchronous value update so the display never shows a torn value.

---
 rtl/seg_scan_driver.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Four-digit seven-segment scan controller: time-multiplexes a 16-bit hex value
// with per-slot dead time, leading-zero suppression and frame-synchronous update.
module seg_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [1:0]  digit_sel,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [19:0]   staging;
    logic [19:0]   shadow;
    logic          pending;

    logic          slot_end;
    logic          wrap;
    logic          xfer;
    logic [3:0]    nibble;
    logic          dp_bit;
    logic          blank3;
    logic          blank2;
    logic          blank1;
    logic          digit_blank;
    logic          dead;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign slot_end = (cnt == CNT_MAX);
    assign wrap     = slot_end && (digit_sel == 2'd3);
    // While disabled the display is dark, so a pending value can move at any time.
    assign xfer     = !enable || wrap;
    assign dead     = !enable || (cnt < CNT_BLANK);

    assign blank3 = blank_lz && (shadow[15:12] == 4'h0);
    assign blank2 = blank3 && (shadow[11:8] == 4'h0);
    assign blank1 = blank2 && (shadow[7:4] == 4'h0);

    always_comb begin
        nibble      = shadow[3:0];
        dp_bit      = shadow[16];
        digit_blank = 1'b0;
        case (digit_sel)
            2'd0: begin nibble = shadow[3:0];   dp_bit = shadow[16]; digit_blank = 1'b0;   end
            2'd1: begin nibble = shadow[7:4];   dp_bit = shadow[17]; digit_blank = blank1; end
            2'd2: begin nibble = shadow[11:8];  dp_bit = shadow[18]; digit_blank = blank2; end
            default: begin nibble = shadow[15:12]; dp_bit = shadow[19]; digit_blank = blank3; end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            digit_sel   <= 2'd0;
            frame_start <= 1'b0;
        end else if (!enable) begin
            cnt         <= '0;
            digit_sel   <= 2'd0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap;
            if (slot_end) begin
                cnt       <= '0;
                digit_sel <= digit_sel + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // A load coinciding with the transfer point bypasses staging so it is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            staging <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else begin
            if (load)
                staging <= {dp_in, value};
            if (xfer && load) begin
                shadow  <= {dp_in, value};
                pending <= 1'b0;
            end else if (xfer && pending) begin
                shadow  <= staging;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else if (dead) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << digit_sel);
            seg <= digit_blank ? 7'b1111111 : hex7(nibble);
            dp  <= ~dp_bit;
        end
    end

endmodule
